vx_tex_bus_responder: RTL and testbench
=======================================

Name: vx_tex_bus_responder

Overview:
- Texture-unit-side endpoint of the tex bus; the SFU texture agent is the initiator on the other end.
- Accepts requests from NUM_REQS core-side masters and arbitrates them round-robin onto one texture-pipeline request port.
- Remaps each request's tag to an internal slot tag and tracks the pipeline's out-of-order responses.
- Routes every response back to its source master with the original tag restored.

Parameters:
- NUM_REQS, 4: number of core-side tex bus masters.
- REQ_DATAW, 256: request payload bits (lanes, coords, stage).
- RSP_DATAW, 128: response payload bits (texels).
- TAG_WIDTH, 8: external tag width.
- MAX_PENDING, 16: outstanding request slots; power of 2, ≥2.
- SLOT_BITS, CLOG2(MAX_PENDING): derived, internal tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  NUM_REQS  per-master request valid.
- req_data  in  NUM_REQS*REQ_DATAW  request payloads.
- req_tag  in  NUM_REQS*TAG_WIDTH  external tags.
- req_ready  out  NUM_REQS  per-master accept.
- rsp_valid  out  NUM_REQS  per-master response valid.
- rsp_data  out  NUM_REQS*RSP_DATAW  response payloads.
- rsp_tag  out  NUM_REQS*TAG_WIDTH  restored external tags.
- rsp_ready  in  NUM_REQS  per-master response accept.
- pipe_req_valid  out  1  request to the texture pipeline.
- pipe_req_data  out  REQ_DATAW  forwarded payload.
- pipe_req_tag  out  SLOT_BITS  internal slot tag.
- pipe_req_ready  in  1  pipeline accept.
- pipe_rsp_valid  in  1  pipeline response valid.
- pipe_rsp_data  in  RSP_DATAW  response payload.
- pipe_rsp_tag  in  SLOT_BITS  slot tag of the response.
- pipe_rsp_ready  out  1  response accept.

Behaviour:
- Reset (reset=0, async):
  - Slot table is cleared to all-free.
  - RR pointer is 0.
  - Output skid buffers are emptied.
  - All valid and ready outputs are 0.
  - Reset mid-operation drops all in-flight state; the pipeline is reset by the same signal.
- Request path:
  - The RR arbiter picks one valid master, starting search at the pointer.
  - A grant requires a free slot and an empty-or-draining pipe_req output register.
  - The lowest-index free slot is allocated.
  - The slot stores {source index, req_tag}; payload and slot index are registered into pipe_req_*.
  - req_ready is high for the granted master only, in the same cycle (combinational from the arbitration).
  - The RR pointer advances to grant+1 mod NUM_REQS on each transfer.
  - Latency: request accept to pipe_req_valid = 1 cycle.
  - pipe_req_* hold stable while valid and not ready.
- Full condition: when all MAX_PENDING slots are busy, all req_ready are 0. No request is dropped.
- Response path:
  - On pipe_rsp_valid, slot pipe_rsp_tag is looked up to obtain the source index and the original tag.
  - pipe_rsp_ready = 1 iff that source's 2-entry skid buffer is not full.
  - On transfer, the slot is freed and the response is written to that source's buffer.
  - Latency: pipe_rsp transfer to rsp_valid = 1 cycle.
  - Per-source response order follows pipeline return order.
- Simultaneous events:
  - Allocation and free in the same cycle are both legal.
  - A slot freed in cycle N is allocatable from cycle N+1, never in cycle N.
- Errors:
  - A response to a free slot is a protocol error: it triggers an assertion in simulation and the response is dropped.
  - A duplicate tag from the same master is allowed, since each request gets its own slot.
- Pointer wrap-around: after NUM_REQS-1 the RR pointer wraps to 0.

Optional Feature:
- Macro: TEX_BUS_PERF_EN.
- Enabled:
  - Adds output perf_stall_cycles (32 bits): counts cycles with any req_valid high while the table is full.
  - Adds output perf_pending (SLOT_BITS+1 bits): current busy-slot count.
  - Both reset to 0; the counter saturates at all-ones.
- Disabled: the ports and logic are absent.

Decomposition:
- Shared package holds:
  - the slot-entry typedef {src index CLOG2(NUM_REQS), tag TAG_WIDTH};
  - the default MAX_PENDING constant;
  - the perf-counter width constant.
- One sub-module, vx_tex_slot_alloc:
  - busy bitmap, lowest-free priority encoder, full flag;
  - allocate and free ports, and the pending count.

Test Plan:
1. Single request: master 2 sends tag 0x5A → pipe_req_tag=0 one cycle later; pipe returns tag 0 → rsp_valid[2]=1 with rsp_tag=0x5A one cycle later.
2. Fairness: all 4 masters continuously valid, pipe always ready → grants 0,1,2,3,0,… with each master granted once per 4 transfers.
3. Full: pipe never responds and 16 requests are accepted → all req_ready=0; one response on slot 7 → next grant uses slot 7 one cycle later, not the same cycle.
4. Out-of-order return: slots 0,1,2 are issued to masters 0,1,0 and returned in order 2,0,1 → master 0 sees tags of slot 2 then slot 0; master 1 sees slot 1's tag.
5. Backpressure: rsp_ready[1]=0 while 3 responses for master 1 arrive → third pipe_rsp stalls (pipe_rsp_ready=0) with its slot still busy; responses for master 0 still flow.
6. Reset mid-flight: reset pulses low with 5 slots busy → all outputs 0 immediately and the table is empty; the next request is allocated slot 0.

Source files
------------

// File: rtl/vx_tex_bus_responder_pkg.sv
// Shared types and constants for the tex bus responder and its slot allocator.
// The slot-entry layout is sized from the default master count and tag width.
package vx_tex_bus_responder_pkg;

  localparam int TEX_NUM_REQS    = 4;
  localparam int TEX_TAG_WIDTH   = 8;
  localparam int TEX_SRC_BITS    = $clog2(TEX_NUM_REQS);
  localparam int TEX_MAX_PENDING = 16;
  localparam int TEX_PERF_CNT_W  = 32;

  typedef struct packed {
    logic [TEX_SRC_BITS-1:0]  src;
    logic [TEX_TAG_WIDTH-1:0] tag;
  } tex_slot_entry_t;

endpackage

// File: rtl/vx_tex_bus_responder_slot_alloc.sv
// Outstanding-slot bookkeeping: busy bitmap, lowest-free allocation, full flag and
// pending count. Allocation sees only the registered bitmap, so a slot freed this cycle is reusable next cycle.
module vx_tex_slot_alloc
  import vx_tex_bus_responder_pkg::*;
#(
  parameter int MAX_PENDING = TEX_MAX_PENDING,
  parameter int SLOT_BITS   = $clog2(MAX_PENDING)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_i,
  input  logic                   free_i,
  input  logic [SLOT_BITS-1:0]   free_idx_i,
  output logic [SLOT_BITS-1:0]   alloc_idx_o,
  output logic                   full_o,
  output logic [MAX_PENDING-1:0] busy_o,
  output logic [SLOT_BITS:0]     count_o
);

  logic [MAX_PENDING-1:0] busy_q, busy_d;

  always_comb begin
    alloc_idx_o = '0;
    for (int i = MAX_PENDING-1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx_o = SLOT_BITS'(i);
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      count_o = count_o + (SLOT_BITS+1)'(busy_q[i]);
    end
  end

  assign full_o = &busy_q;
  assign busy_o = busy_q;

  always_comb begin
    busy_d = busy_q;
    if (alloc_i) busy_d[alloc_idx_o] = 1'b1;
    if (free_i)  busy_d[free_idx_i]  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/vx_tex_bus_responder.sv
// Texture-side tex bus endpoint: round-robin request arbitration with slot-tag remap,
// out-of-order response routing into per-master 2-entry buffers. Optional perf counters: TEX_BUS_PERF_EN.
module vx_tex_bus_responder
  import vx_tex_bus_responder_pkg::*;
#(
  parameter int NUM_REQS    = TEX_NUM_REQS,
  parameter int REQ_DATAW   = 256,
  parameter int RSP_DATAW   = 128,
  parameter int TAG_WIDTH   = TEX_TAG_WIDTH,
  parameter int MAX_PENDING = TEX_MAX_PENDING,
  parameter int SLOT_BITS   = $clog2(MAX_PENDING)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS*REQ_DATAW-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic [NUM_REQS-1:0]           rsp_valid,
  output logic [NUM_REQS*RSP_DATAW-1:0] rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0] rsp_tag,
  input  logic [NUM_REQS-1:0]           rsp_ready,
  output logic                          pipe_req_valid,
  output logic [REQ_DATAW-1:0]          pipe_req_data,
  output logic [SLOT_BITS-1:0]          pipe_req_tag,
  input  logic                          pipe_req_ready,
  input  logic                          pipe_rsp_valid,
  input  logic [RSP_DATAW-1:0]          pipe_rsp_data,
  input  logic [SLOT_BITS-1:0]          pipe_rsp_tag,
  output logic                          pipe_rsp_ready
`ifdef TEX_BUS_PERF_EN
  ,
  output logic [TEX_PERF_CNT_W-1:0]     perf_stall_cycles,
  output logic [SLOT_BITS:0]            perf_pending
`endif
);

  localparam int SRC_BITS = $clog2(NUM_REQS);

  logic [SRC_BITS-1:0]    rr_ptr_q, rr_ptr_d, grant_idx, cand_idx;
  logic                   grant_vld, req_fire;
  logic                   pipe_req_valid_q;
  logic [REQ_DATAW-1:0]   pipe_req_data_q;
  logic [SLOT_BITS-1:0]   pipe_req_tag_q;
  logic [SLOT_BITS-1:0]   alloc_idx;
  logic                   tbl_full;
  logic [MAX_PENDING-1:0] slot_busy;
  logic [SLOT_BITS:0]     pending_cnt;
  tex_slot_entry_t        slot_tbl_q [MAX_PENDING];
  tex_slot_entry_t        rsp_ent;
  logic                   rsp_slot_busy, rsp_fire, rsp_push;
  logic [NUM_REQS-1:0]    buf_full;

  // Search starts at the pointer; iterating downward leaves the closest valid master.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int i = NUM_REQS-1; i >= 0; i--) begin
      cand_idx = SRC_BITS'((int'(rr_ptr_q) + i) % NUM_REQS);
      if (req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign rr_ptr_d  = (grant_idx == SRC_BITS'(NUM_REQS-1)) ? '0 : grant_idx + 1'b1;
  assign req_fire  = reset && grant_vld && !tbl_full && (!pipe_req_valid_q || pipe_req_ready);
  assign req_ready = req_fire ? (NUM_REQS'(1) << grant_idx) : '0;

  vx_tex_slot_alloc #(
    .MAX_PENDING (MAX_PENDING),
    .SLOT_BITS   (SLOT_BITS)
  ) u_slot_alloc (
    .clk         (clk),
    .rst_n       (reset),
    .alloc_i     (req_fire),
    .free_i      (rsp_push),
    .free_idx_i  (pipe_rsp_tag),
    .alloc_idx_o (alloc_idx),
    .full_o      (tbl_full),
    .busy_o      (slot_busy),
    .count_o     (pending_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_req_valid_q <= 1'b0;
      rr_ptr_q         <= '0;
    end else if (req_fire) begin
      pipe_req_valid_q <= 1'b1;
      rr_ptr_q         <= rr_ptr_d;
    end else if (pipe_req_ready) begin
      pipe_req_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pipe_req_data_q           <= req_data[grant_idx*REQ_DATAW +: REQ_DATAW];
      pipe_req_tag_q            <= alloc_idx;
      slot_tbl_q[alloc_idx].src <= TEX_SRC_BITS'(grant_idx);
      slot_tbl_q[alloc_idx].tag <= req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  assign pipe_req_valid = pipe_req_valid_q;
  assign pipe_req_data  = pipe_req_data_q;
  assign pipe_req_tag   = pipe_req_tag_q;

  // A response to a free slot is accepted and discarded so the pipeline cannot wedge on it.
  assign rsp_ent        = slot_tbl_q[pipe_rsp_tag];
  assign rsp_slot_busy  = slot_busy[pipe_rsp_tag];
  assign pipe_rsp_ready = reset && (rsp_slot_busy ? !buf_full[rsp_ent.src] : 1'b1);
  assign rsp_fire       = pipe_rsp_valid && pipe_rsp_ready;
  assign rsp_push       = rsp_fire && rsp_slot_busy;

  for (genvar s = 0; s < NUM_REQS; s++) begin : g_rsp_buf
    logic [RSP_DATAW-1:0] buf_data_q [2];
    logic [TAG_WIDTH-1:0] buf_tag_q  [2];
    logic                 buf_wp_q, buf_rp_q;
    logic [1:0]           buf_cnt_q;
    logic                 push_s, pop_s;

    assign push_s = rsp_push && (rsp_ent.src == TEX_SRC_BITS'(s));
    assign pop_s  = rsp_valid[s] && rsp_ready[s];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        buf_wp_q  <= 1'b0;
        buf_rp_q  <= 1'b0;
        buf_cnt_q <= 2'd0;
      end else begin
        if (push_s) buf_wp_q <= ~buf_wp_q;
        if (pop_s)  buf_rp_q <= ~buf_rp_q;
        buf_cnt_q <= buf_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
      end
    end

    always_ff @(posedge clk) begin
      if (push_s) begin
        buf_data_q[buf_wp_q] <= pipe_rsp_data;
        buf_tag_q[buf_wp_q]  <= rsp_ent.tag;
      end
    end

    assign rsp_valid[s]                         = (buf_cnt_q != 2'd0);
    assign buf_full[s]                          = (buf_cnt_q == 2'd2);
    assign rsp_data[s*RSP_DATAW +: RSP_DATAW]   = buf_data_q[buf_rp_q];
    assign rsp_tag[s*TAG_WIDTH +: TAG_WIDTH]    = buf_tag_q[buf_rp_q];
  end

  assert property (@(posedge clk) disable iff (!reset) pipe_rsp_valid |-> rsp_slot_busy);
  assert property (@(posedge clk) disable iff (!reset) req_fire |-> (pending_cnt < (SLOT_BITS+1)'(MAX_PENDING)));

`ifdef TEX_BUS_PERF_EN
  logic [TEX_PERF_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else if ((|req_valid) && tbl_full && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_pending      = pending_cnt;
`endif

endmodule

// File: tb/tb_vx_tex_bus_responder.sv
// Randomized bench for vx_tex_bus_responder against a transaction-level model
// (slot set, RR pointer, per-master expected response queues).
module tb_vx_tex_bus_responder;

  localparam int N  = 4;
  localparam int RQ = 256;
  localparam int RS = 128;
  localparam int TW = 8;
  localparam int MP = 16;
  localparam int SB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*RQ-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*RS-1:0] rsp_data;
  logic [N*TW-1:0] rsp_tag;
  logic [N-1:0]    rsp_ready;
  logic            pipe_req_valid;
  logic [RQ-1:0]   pipe_req_data;
  logic [SB-1:0]   pipe_req_tag;
  logic            pipe_req_ready;
  logic            pipe_rsp_valid;
  logic [RS-1:0]   pipe_rsp_data;
  logic [SB-1:0]   pipe_rsp_tag;
  logic            pipe_rsp_ready;

  always #5 clk = ~clk;

  vx_tex_bus_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_tag        (req_tag),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .rsp_ready      (rsp_ready),
    .pipe_req_valid (pipe_req_valid),
    .pipe_req_data  (pipe_req_data),
    .pipe_req_tag   (pipe_req_tag),
    .pipe_req_ready (pipe_req_ready),
    .pipe_rsp_valid (pipe_rsp_valid),
    .pipe_rsp_data  (pipe_rsp_data),
    .pipe_rsp_tag   (pipe_rsp_tag),
    .pipe_rsp_ready (pipe_rsp_ready)
  );

  typedef struct { logic [RQ-1:0] d; int slot; } preq_t;
  typedef struct { logic [RS-1:0] d; logic [TW-1:0] t; } rsp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ptr;
  bit          mbusy  [MP];
  bit          issued [MP];
  int          s_src  [MP];
  logic [TW-1:0] s_tag [MP];
  preq_t       pq [$];
  rsp_t        oq [N][$];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    ptr = 0;
    for (int i = 0; i < MP; i++) begin
      mbusy[i] = 0; issued[i] = 0;
    end
    pq.delete();
    for (int s = 0; s < N; s++) oq[s].delete();
  endtask

  task automatic drive_idle();
    req_valid = '0; req_data = '0; req_tag = '0;
    rsp_ready = '1; pipe_req_ready = 1'b1;
    pipe_rsp_valid = 1'b0; pipe_rsp_data = '0; pipe_rsp_tag = '0;
  endtask

  task automatic drive_rand(input int p_req, input int p_prdy, input int p_rsp, input int p_rrdy);
    int cand[$];
    for (int m = 0; m < N; m++) begin
      req_valid[m] = ($urandom_range(99) < p_req);
      req_tag[m*TW +: TW] = TW'($urandom);
      for (int k = 0; k < RQ/32; k++) req_data[m*RQ + k*32 +: 32] = $urandom;
      rsp_ready[m] = ($urandom_range(99) < p_rrdy);
    end
    pipe_req_ready = ($urandom_range(99) < p_prdy);
    for (int i = 0; i < MP; i++) if (issued[i]) cand.push_back(i);
    pipe_rsp_valid = 1'b0;
    if (cand.size() > 0 && $urandom_range(99) < p_rsp) begin
      pipe_rsp_valid = 1'b1;
      pipe_rsp_tag   = SB'(cand[$urandom_range(cand.size()-1)]);
      for (int k = 0; k < RS/32; k++) pipe_rsp_data[k*32 +: 32] = $urandom;
    end
  endtask

  // Called just after inputs are driven at a falling edge; ends at the next falling edge.
  task automatic cycle();
    int g, lf, src;
    logic [N-1:0] exp_rr;
    bit exp_prdy;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
    lf = -1;
    for (int i = MP-1; i >= 0; i--) if (!mbusy[i]) lf = i;
    exp_rr = (g >= 0 && lf >= 0 && (pq.size() == 0 || pipe_req_ready)) ? N'(1 << g) : '0;
    chk("req_ready", req_ready, exp_rr);
    chk("pipe_req_valid", pipe_req_valid, pq.size() != 0);
    if (pq.size() != 0) begin
      chk("pipe_req_tag", pipe_req_tag, pq[0].slot);
      chk("pipe_req_data", pipe_req_data, pq[0].d);
    end
    exp_prdy = 0;
    src = 0;
    if (pipe_rsp_valid) begin
      src = s_src[pipe_rsp_tag];
      exp_prdy = (oq[src].size() < 2);
      chk("pipe_rsp_ready", pipe_rsp_ready, exp_prdy);
    end
    for (int s = 0; s < N; s++) begin
      chk($sformatf("rsp_valid%0d", s), rsp_valid[s], oq[s].size() != 0);
      if (oq[s].size() != 0) begin
        chk($sformatf("rsp_tag%0d", s), rsp_tag[s*TW +: TW], oq[s][0].t);
        chk($sformatf("rsp_data%0d", s), rsp_data[s*RS +: RS], oq[s][0].d);
        if (rsp_ready[s]) void'(oq[s].pop_front());
      end
    end
    if (pq.size() != 0 && pipe_req_ready) issued[pq.pop_front().slot] = 1;
    if (exp_rr != 0) begin
      pq.push_back('{d: req_data[g*RQ +: RQ], slot: lf});
      mbusy[lf] = 1; s_src[lf] = g; s_tag[lf] = req_tag[g*TW +: TW];
      ptr = (g + 1) % N;
    end
    if (pipe_rsp_valid && exp_prdy) begin
      oq[src].push_back('{d: pipe_rsp_data, t: s_tag[pipe_rsp_tag]});
      mbusy[pipe_rsp_tag] = 0; issued[pipe_rsp_tag] = 0;
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_pipe_req_valid"}, pipe_req_valid, 1'b0);
    chk({tag, "_pipe_rsp_ready"}, pipe_rsp_ready, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    req_valid = '1;
    model_clear();
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    drive_idle();

    // Single request: master 2, tag 0x5A, returned on slot 0.
    req_valid = 4'b0100; req_tag[2*TW +: TW] = 8'h5A;
    cycle();
    drive_idle();
    cycle();
    pipe_rsp_valid = 1'b1; pipe_rsp_tag = '0; pipe_rsp_data = {4{32'hC0FFEE01}};
    cycle();
    drive_idle();
    #1 chk("single_rsp_tag", rsp_tag[2*TW +: TW], 8'h5A);
    cycle();

    for (int c = 0; c < 600; c++) begin drive_rand(60, 70, 40, 80); cycle(); end
    // Fill the table: no responses returned.
    for (int c = 0; c < 80; c++)  begin drive_rand(80, 90, 0, 100); cycle(); end
    for (int c = 0; c < 60; c++)  begin drive_rand(90, 90, 30, 100); cycle(); end
    // Heavy response backpressure.
    for (int c = 0; c < 400; c++) begin drive_rand(50, 80, 60, 20); cycle(); end

    // Reset in flight.
    drive_rand(100, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_idle();
    req_valid = 4'b0010;
    cycle();
    drive_idle();
    #1 chk("post_reset_slot", pipe_req_tag, 0);
    cycle();

    for (int c = 0; c < 300; c++) begin drive_rand(60, 70, 50, 70); cycle(); end
    for (int c = 0; c < 100; c++) begin drive_rand(0, 100, 100, 100); cycle(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
